pipeline_stall_ctrl: RTL and testbench

- Consumes the hazard requests raised by the ID-stage data-hazard/forwarding checker: load-use stop request, EX-resolved control redirect, DRAM busy, and WB halt.
- Turns them into per-stage write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB in the 5-stage RV32I pipeline.
- Owns the post-reset pipeline-clear sequence, the halt state, the DRAM-wait watchdog and the hazard performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 46 ++++
 rtl/pipe_perf_counters.sv | 24 ++
 rtl/pipeline_stall_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline control slice.
// Holds the controller state encoding, the bubble (NOP) encoding loaded by
// stage registers on flush, opcode constants shared with the ID hazard
// checker, the per-stage control bundle, and perf-counter slot indices.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  // addi x0, x0, 0 -- what a flushed stage register holds (rf_we=0)
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_OPIMM  = 7'b001_0011;
  localparam logic [6:0] OP_OP     = 7'b011_0011;
  localparam logic [6:0] OP_SYSTEM = 7'b111_0011;

  // Per-stage enables/flushes driven out of the controller
  typedef struct packed {
    logic        pc_we;
    logic        pc_redirect;
    logic [31:0] npc_target;
    logic        if_id_we;
    logic        id_ex_we;
    logic        ex_mem_we;
    logic        mem_wb_we;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_flush;
    logic        halted;
  } stage_ctrl_t;

  // Perf counter slots
  localparam int NUM_CNT   = 3;
  localparam int CNT_CYC   = 0;
  localparam int CNT_STALL = 1;
  localparam int CNT_FLUSH = 2;

endpackage

// File: rtl/pipe_perf_counters.sv
// Hazard performance counters: one free-running wrapping counter per slot,
// each advanced by its own increment enable.
// Ports: clk, rst (async high), inc[NUM_CNT] enables, cnt[NUM_CNT] values.
module pipe_perf_counters
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CNT-1:0]              inc,
  output logic [NUM_CNT-1:0][CNT_W-1:0]   cnt
);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    logic [CNT_W-1:0] q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         q <= '0;
      else if (inc[i]) q <= q + 1'b1;   // wraps modulo 2^CNT_W
    end
    assign cnt[i] = q;
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller for the 5-stage RV32I core.
// Turns hazard requests (load-use, EX redirect, DRAM busy, WB halt) into
// per-stage write enables and bubble flushes; runs the one-cycle post-reset
// clear, the halt state, the DRAM-wait watchdog and the perf counters.
// Ports:
//   clk, rst (async high)
//   lu_stall_req, ex_redirect, ex_redirect_pc, mem_busy, wb_halt  -- requests
//   pc_we, pc_redirect, npc_target                                -- PC control
//   *_we, *_flush                                                 -- stage regs
//   halted, hz_err                                                -- status
//   stall_cnt, flush_cnt, cycle_cnt                               -- counters
module pipeline_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          CNT_W       = 32,
  parameter int          MEM_TIMEOUT = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lu_stall_req,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_redirect_pc,
  input  logic             mem_busy,
  input  logic             wb_halt,
  output logic             pc_we,
  output logic             pc_redirect,
  output logic [31:0]      npc_target,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             hz_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_e            state_q, state_d;
  stage_ctrl_t       ctrl;
  logic              run;
  logic              take_freeze, take_redir, take_lu;
  logic              lu_prev;
  logic [WAIT_W-1:0] wait_cnt;
  logic              lu_err, wd_err;

  assign run = (state_q == RUN);

  // Next state + stage controls. Priority order in RUN:
  // freeze on DRAM busy > EX redirect > load-use stall > normal flow.
  always_comb begin
    ctrl        = '0;
    state_d     = state_q;
    take_freeze = 1'b0;
    take_redir  = 1'b0;
    take_lu     = 1'b0;
    unique case (state_q)
      INIT: begin
        ctrl.pc_we        = 1'b1;
        ctrl.pc_redirect  = 1'b1;
        ctrl.npc_target   = RESET_PC;
        ctrl.if_id_flush  = 1'b1;
        ctrl.id_ex_flush  = 1'b1;
        ctrl.mem_wb_flush = 1'b1;
        state_d           = RUN;
      end
      RUN: begin
        if (mem_busy) begin
          // EX is held, so a pending redirect re-asserts once MEM finishes
          take_freeze       = 1'b1;
          ctrl.mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
          // ID instruction is killed, so any load-use request is moot
          take_redir        = 1'b1;
          ctrl.pc_we        = 1'b1;
          ctrl.pc_redirect  = 1'b1;
          ctrl.npc_target   = ex_redirect_pc;
          ctrl.if_id_we     = 1'b1;
          ctrl.id_ex_we     = 1'b1;
          ctrl.ex_mem_we    = 1'b1;
          ctrl.mem_wb_we    = 1'b1;
          ctrl.if_id_flush  = 1'b1;
          ctrl.id_ex_flush  = 1'b1;
        end else if (lu_stall_req) begin
          // hold PC and IF/ID, inject a bubble into EX, let EX..WB drain
          take_lu          = 1'b1;
          ctrl.id_ex_we    = 1'b1;
          ctrl.ex_mem_we   = 1'b1;
          ctrl.mem_wb_we   = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end else begin
          ctrl.pc_we     = 1'b1;
          ctrl.if_id_we  = 1'b1;
          ctrl.id_ex_we  = 1'b1;
          ctrl.ex_mem_we = 1'b1;
          ctrl.mem_wb_we = 1'b1;
        end
        // halt wins over a DRAM freeze for the transition only
        if (wb_halt) state_d = HALT;
      end
      HALT: ctrl.halted = 1'b1;
      default: state_d = INIT;
    endcase
  end

  // A second load-use request right after a stall would target the bubble
  assign lu_err = run && lu_stall_req && lu_prev && !mem_busy;
  // Fires on the edge where wait_cnt reaches MEM_TIMEOUT
  assign wd_err = run && mem_busy && (wait_cnt >= WAIT_MAX - 1'b1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= INIT;
      lu_prev  <= 1'b0;
      wait_cnt <= '0;
      hz_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      lu_prev <= take_lu;
      if (run && mem_busy) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (lu_err || wd_err) hz_err <= 1'b1;
    end
  end

  logic [NUM_CNT-1:0]            cnt_inc;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt;

  always_comb begin
    cnt_inc            = '0;
    cnt_inc[CNT_CYC]   = run;
    cnt_inc[CNT_STALL] = take_freeze | take_lu;
    cnt_inc[CNT_FLUSH] = take_redir;
  end

  pipe_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .cnt (cnt)
  );

  assign cycle_cnt = cnt[CNT_CYC];
  assign stall_cnt = cnt[CNT_STALL];
  assign flush_cnt = cnt[CNT_FLUSH];

  assign pc_we        = ctrl.pc_we;
  assign pc_redirect  = ctrl.pc_redirect;
  assign npc_target   = ctrl.npc_target;
  assign if_id_we     = ctrl.if_id_we;
  assign id_ex_we     = ctrl.id_ex_we;
  assign ex_mem_we    = ctrl.ex_mem_we;
  assign mem_wb_we    = ctrl.mem_wb_we;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign mem_wb_flush = ctrl.mem_wb_flush;
  assign halted       = ctrl.halted;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl. Inputs change on the falling edge,
// combinational outputs are checked 1 ns later, registered results are
// checked on the following falling edge.
module tb_pipeline_stall_ctrl;

  localparam int CNT_W = 32;

  // {pc_we,pc_redirect,if_id_we,id_ex_we,ex_mem_we,mem_wb_we,
  //  if_id_flush,id_ex_flush,mem_wb_flush,halted}
  localparam logic [9:0] V_INIT   = 10'b11_0000_111_0;
  localparam logic [9:0] V_RUN    = 10'b10_1111_000_0;
  localparam logic [9:0] V_LU     = 10'b00_0111_010_0;
  localparam logic [9:0] V_REDIR  = 10'b11_1111_110_0;
  localparam logic [9:0] V_FREEZE = 10'b00_0000_001_0;
  localparam logic [9:0] V_HALT   = 10'b00_0000_000_1;

  logic clk = 1'b0;
  logic rst;
  logic lu_stall_req, ex_redirect, mem_busy, wb_halt;
  logic [31:0] ex_redirect_pc;
  logic pc_we, pc_redirect, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, mem_wb_flush, halted, hz_err;
  logic [31:0] npc_target;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, cycle_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .lu_stall_req(lu_stall_req), .ex_redirect(ex_redirect),
    .ex_redirect_pc(ex_redirect_pc), .mem_busy(mem_busy), .wb_halt(wb_halt),
    .pc_we(pc_we), .pc_redirect(pc_redirect), .npc_target(npc_target),
    .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .hz_err(hz_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .cycle_cnt(cycle_cnt)
  );

  wire [9:0] vec = {pc_we, pc_redirect, if_id_we, id_ex_we, ex_mem_we,
                    mem_wb_we, if_id_flush, id_ex_flush, mem_wb_flush, halted};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clr_in();
    lu_stall_req   = 1'b0;
    ex_redirect    = 1'b0;
    ex_redirect_pc = 32'h0;
    mem_busy       = 1'b0;
    wb_halt        = 1'b0;
  endtask

  // Pulse reset, release on a falling edge, then pass through INIT into RUN
  task automatic do_reset();
    rst = 1'b1;
    #2;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("init_vec", 64'(vec), 64'(V_INIT));
    step();
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    @(negedge clk);
    @(negedge clk);
    chk("rst_vec", 64'(vec), 64'(V_INIT));
    chk("rst_cyc", 64'(cycle_cnt), 64'd0);
    chk("rst_err", 64'(hz_err), 64'd0);

    // reset release: one INIT cycle, then RUN
    rst = 1'b0;
    #1;
    chk("init_vec", 64'(vec), 64'(V_INIT));
    chk("init_npc", 64'(npc_target), 64'h0);
    step();
    chk("run_vec", 64'(vec), 64'(V_RUN));
    chk("run_cyc0", 64'(cycle_cnt), 64'd0);
    step();
    chk("run_cyc1", 64'(cycle_cnt), 64'd1);

    // load-use: one cycle stalls cleanly, a second one back-to-back errors
    lu_stall_req = 1'b1;
    #1;
    chk("lu_vec", 64'(vec), 64'(V_LU));
    step();
    chk("lu_stall1", 64'(stall_cnt), 64'd1);
    chk("lu_err0", 64'(hz_err), 64'd0);
    #1;
    chk("lu_vec2", 64'(vec), 64'(V_LU));
    step();
    chk("lu_err1", 64'(hz_err), 64'd1);
    chk("lu_stall2", 64'(stall_cnt), 64'd2);
    clr_in();

    // redirect beats load-use
    do_reset();
    chk("rst_err_clr", 64'(hz_err), 64'd0);
    ex_redirect = 1'b1; ex_redirect_pc = 32'h40; lu_stall_req = 1'b1;
    #1;
    chk("redir_vec", 64'(vec), 64'(V_REDIR));
    chk("redir_npc", 64'(npc_target), 64'h40);
    step();
    chk("redir_flush", 64'(flush_cnt), 64'd1);
    chk("redir_stall", 64'(stall_cnt), 64'd0);
    clr_in();
    #1;
    chk("idle_npc", 64'(npc_target), 64'h0);

    // DRAM busy freezes everything, pending redirect lands afterwards
    mem_busy = 1'b1; ex_redirect = 1'b1; ex_redirect_pc = 32'h80;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_vec", 64'(vec), 64'(V_FREEZE));
      chk("frz_npc", 64'(npc_target), 64'h0);
      step();
    end
    mem_busy = 1'b0;
    #1;
    chk("frz_redir_vec", 64'(vec), 64'(V_REDIR));
    chk("frz_redir_npc", 64'(npc_target), 64'h80);
    chk("frz_stall", 64'(stall_cnt), 64'd3);
    step();
    chk("frz_flush", 64'(flush_cnt), 64'd2);
    chk("frz_err", 64'(hz_err), 64'd0);
    clr_in();

    // watchdog: error lands on the 16th busy edge and is sticky
    do_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("wd_err15", 64'(hz_err), 64'd0);
    step();
    chk("wd_err16", 64'(hz_err), 64'd1);
    chk("wd_stall", 64'(stall_cnt), 64'd16);
    mem_busy = 1'b0;
    #1;
    chk("wd_run_vec", 64'(vec), 64'(V_RUN));
    step();
    chk("wd_sticky", 64'(hz_err), 64'd1);

    // halt beats a DRAM freeze for the transition; HALT ignores inputs
    do_reset();
    step();
    chk("h_cyc1", 64'(cycle_cnt), 64'd1);
    wb_halt = 1'b1; mem_busy = 1'b1;
    #1;
    chk("h_frz_vec", 64'(vec), 64'(V_FREEZE));
    step();
    clr_in();
    ex_redirect = 1'b1; ex_redirect_pc = 32'h100; lu_stall_req = 1'b1;
    #1;
    chk("halt_vec", 64'(vec), 64'(V_HALT));
    chk("halt_npc", 64'(npc_target), 64'h0);
    chk("halt_cyc", 64'(cycle_cnt), 64'd2);
    step();
    step();
    chk("halt_cyc_frozen", 64'(cycle_cnt), 64'd2);
    chk("halt_stall", 64'(stall_cnt), 64'd1);
    chk("halt_vec2", 64'(vec), 64'(V_HALT));

    // async reset in the middle of a cycle takes effect immediately
    #2;
    rst = 1'b1;
    #1;
    chk("arst_vec", 64'(vec), 64'(V_INIT));
    chk("arst_cyc", 64'(cycle_cnt), 64'd0);
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    chk("arst_flush", 64'(flush_cnt), 64'd0);
    clr_in();
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("arst_run", 64'(vec), 64'(V_RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // hard stop if something wedges the sequence
  initial begin
    #100000;
    $display("FAIL timeout: sequence did not complete, got stuck expected done");
    $fatal(1);
  end

endmodule
